// File: rtl/proc_run_controller_if.sv
// Control bundle between the bench (or board control) and the run controller.
// dbg_state mirrors the controller FSM state so checkers can bind to it.
interface proc_run_controller_if #(
  parameter int CNT_WIDTH = 16
);
  // start/abort are level requests sampled on every rising edge; there is no
  // ready: start is taken only in IDLE or DONE and dropped otherwise, while
  // abort is always taken. Outputs are registered status, valid every cycle.
  logic                 start;
  logic                 abort;
  logic                 halt_in;
  logic                 proc_reset;
  logic                 running;
  logic                 done;
  logic                 timeout;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [1:0]           dbg_state;

  modport master (
    output start, abort, halt_in,
    input  proc_reset, running, done, timeout, cycle_count, dbg_state
  );

  modport slave (
    input  start, abort, halt_in,
    output proc_reset, running, done, timeout, cycle_count, dbg_state
  );
endinterface

// File: rtl/proc_run_controller.sv
// Run controller for the five-stage processor: holds it in reset, releases it,
// counts run cycles and ends the run on a filtered halt or a cycle budget.
module proc_run_controller #(
  parameter int RESET_CYCLES = 8,
  parameter int MAX_CYCLES   = 50,
  parameter int HALT_FILTER  = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  proc_run_controller_if.slave    ctl
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The halt counter never needs to exceed HALT_FILTER-1 before the run ends.
  localparam int HW = (HALT_FILTER > 1) ? $clog2(HALT_FILTER) : 1;
  localparam logic [HW-1:0]        HALT_LAST = HW'(HALT_FILTER - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RUN_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

  state_t               state_q;
  logic [CNT_WIDTH-1:0] hold_cnt_q;
  logic [CNT_WIDTH-1:0] cycle_cnt_q;
  logic [HW-1:0]        halt_cnt_q;
  logic                 proc_reset_q;
  logic                 running_q;
  logic                 done_q;
  logic                 timeout_q;

  always_ff @(posedge clk) begin
    if (reset || ctl.abort) begin
      state_q      <= S_IDLE;
      hold_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
      halt_cnt_q   <= '0;
      proc_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (ctl.start) begin
            state_q      <= S_HOLD;
            hold_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            halt_cnt_q   <= '0;
            proc_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
          end
        end

        S_HOLD: begin
          hold_cnt_q <= hold_cnt_q + CNT_WIDTH'(1);
          if (hold_cnt_q == HOLD_LAST) begin
            state_q      <= S_RUN;
            proc_reset_q <= 1'b0;
            running_q    <= 1'b1;
            cycle_cnt_q  <= '0;
            halt_cnt_q   <= '0;
          end
        end

        S_RUN: begin
          // The ending edge still counts as a run cycle, so the frozen count
          // includes it.
          cycle_cnt_q <= cycle_cnt_q + CNT_WIDTH'(1);
          halt_cnt_q  <= ctl.halt_in ? halt_cnt_q + HW'(1) : '0;
          if (ctl.halt_in && (halt_cnt_q == HALT_LAST)) begin
            state_q      <= S_DONE;
            halt_cnt_q   <= '0;
            proc_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b1;
            timeout_q    <= 1'b0;
          end else if (cycle_cnt_q == RUN_LAST) begin
            state_q      <= S_DONE;
            halt_cnt_q   <= '0;
            proc_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b1;
            timeout_q    <= 1'b1;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          proc_reset_q <= 1'b1;
          running_q    <= 1'b0;
          done_q       <= 1'b0;
          timeout_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ctl.proc_reset  = proc_reset_q;
  assign ctl.running     = running_q;
  assign ctl.done        = done_q;
  assign ctl.timeout     = timeout_q;
  assign ctl.cycle_count = cycle_cnt_q;
  assign ctl.dbg_state   = state_q;

endmodule

// File: doc/proc_run_controller.md
# proc_run_controller

- Synthesisable run controller for the five-stage pipeline processor.
- Replaces the hand-timed reset and fixed run window used by the processor bench.
- Holds the processor in reset for a parametrised number of cycles, then releases it and counts run cycles.
- Terminates the run on a filtered halt indication or on a cycle budget, and reports done/timeout with a frozen cycle count.
- Sits between the bench (or board-level control) and the `Processor` reset input.

## Interface
Parameters:
- RESET_CYCLES, 8, cycles proc_reset is held high after start is accepted (≥1)
- MAX_CYCLES, 50, run-cycle budget before timeout (≥1)
- HALT_FILTER, 2, consecutive run cycles halt_in must be high to end the run (≥1)
- CNT_WIDTH, 16, width of counters and cycle_count; 2^CNT_WIDTH > max(RESET_CYCLES, MAX_CYCLES)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a run; accepted in IDLE or DONE
- abort  in  1  cancel any run and return to IDLE
- halt_in  in  1  halt indication from processor
- proc_reset  out  1  reset to processor, active-high
- running  out  1  high while in RUN
- done  out  1  high while in DONE
- timeout  out  1  high in DONE when the run ended on budget
- cycle_count  out  CNT_WIDTH  RUN edges elapsed; frozen in DONE

## Operation
- States: IDLE, HOLD, RUN, DONE. All outputs registered.
- Reset values: state IDLE, proc_reset=1, running=0, done=0, timeout=0, cycle_count=0, internal hold/halt counters 0.
- Priority on every edge: reset > abort > start > halt completion > timeout.

IDLE
- proc_reset=1.
- start → HOLD; hold counter=0, cycle_count=0.

HOLD
- proc_reset=1.
- Hold counter increments each edge.
- On the edge where the counter == RESET_CYCLES-1: → RUN, proc_reset=0, running=1, cycle_count=0, halt counter=0.

RUN
- cycle_count += 1 every edge.
- Halt counter: halt_in ? +1 : 0.
- If halt_in && halt counter == HALT_FILTER-1: → DONE, done=1, timeout=0.
- Else if cycle_count == MAX_CYCLES-1 (pre-increment): → DONE, done=1, timeout=1.
- Halt has priority when both conditions occur on the same edge.

DONE
- proc_reset=1, running=0, cycle_count held.
- start → HOLD; clears done/timeout, cycle_count=0.
- halt_in is ignored.

Abort / reset
- abort in any state → IDLE with reset values; it has the same effect as reset.
- start and abort on the same edge → abort wins.
- reset mid-run is identical to abort.

Other rules
- start while in HOLD or RUN is ignored.
- Counters never wrap, because the parameter constraint bounds them.

## Timing
- start sampled high at edge E0 in IDLE → HOLD after E0.
- proc_reset remains high through edge E_R (R = RESET_CYCLES), then falls after E_R together with running rising.
- First RUN edge is E_{R+1}; cycle_count after edge E_{R+k} is k.
- End of run by halt: done rises after the edge where the HALT_FILTER-th consecutive halt_in is sampled.
- Timeout: done and timeout rise after edge E_{R+MAX_CYCLES}, with cycle_count = MAX_CYCLES.
- proc_reset re-asserts on the same edge done rises.
- abort latency: one edge to IDLE.

## Test plan
Defaults R=8, MAX=50, FILTER=2 unless noted.
- **Reset:** reset high 2 edges → proc_reset=1, running=0, done=0, timeout=0, cycle_count=0; start pulse at E0 → proc_reset high through E8, low and running=1 after E8.
- **Halt end:** halt_in high at E20 and E21 → after E21 done=1, timeout=0, cycle_count=13, proc_reset=1; values hold for 10 further cycles.
- **Glitch and timeout:** single-cycle halt_in at E15 then low → run continues; no further halt → after E58 done=1, timeout=1, cycle_count=50.
- **Simultaneous end:** halt_in high at E57 and E58 → done=1, timeout=0, cycle_count=50.
- **Abort and reset mid-run:** abort at E12 → after E12 IDLE, proc_reset=1, running=0, cycle_count=0; start+abort on the same edge in IDLE → stays IDLE; reset at E30 mid-run → same result.
- **Restart and FILTER=1:** start in DONE → done/timeout cleared, cycle_count=0, new 8-cycle HOLD; with HALT_FILTER=1, halt_in at first RUN edge → done with cycle_count=1.
